// File: rtl/elevator_pkg.sv
// Shared state encoding, command op codes and default timing for the car responder.
// Optional door reopen on obstruction is enabled by defining DOOR_REOPEN_EN.
package elevator_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_OPEN  = 2'd2,
        S_CLOSE = 2'd3
    } state_t;

    localparam logic [1:0] OP_OPEN = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam int unsigned NUM_FLOORS_DEF = 8;
    localparam int unsigned TRAVEL_DEF     = 16;
    localparam int unsigned DOOR_DEF       = 32;
    localparam int unsigned CLOSE_DEF      = 8;
    localparam int unsigned TIMER_W_DEF    = 8;

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter shared by the travel, door-open and door-close phases.
// Holds at zero once expired; load takes priority over counting.
module elev_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/car_motion_responder.sv
// Car-command responder: runs timed moves and door cycles, tracks the car floor.
// Define DOOR_REOPEN_EN to reopen the closing door when obstruct is sampled high.
module car_motion_responder
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS    = NUM_FLOORS_DEF,
    parameter int unsigned TRAVEL_CYCLES = TRAVEL_DEF,
    parameter int unsigned DOOR_CYCLES   = DOOR_DEF,
    parameter int unsigned CLOSE_CYCLES  = CLOSE_DEF,
    parameter int unsigned TIMER_W       = TIMER_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    input  logic [1:0]            cmd_op,
    output logic                  cmd_ready,
    output logic [NUM_FLOORS-1:0] floor_oh,
    output logic [2:0]            floor_idx,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  door_open,
    output logic                  arrive,
    output logic                  door_done,
    output logic                  cmd_err,
    input  logic                  obstruct
);

    localparam logic [2:0]         TOP_FLOOR = 3'(NUM_FLOORS - 1);
    localparam logic [TIMER_W-1:0] TRAVEL_LD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LD   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CLOSE_LD  = TIMER_W'(CLOSE_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [2:0]              floor_q, floor_d;
    logic [NUM_FLOORS-1:0]   oh_q, oh_d;
    logic                    dir_q, dir_d;
    logic                    arrive_q, arrive_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    tmr_load;
    logic [TIMER_W-1:0]      tmr_val;
    logic                    tmr_zero;

`ifndef DOOR_REOPEN_EN
    logic unused_obstruct;
    assign unused_obstruct = obstruct;
`endif

    elev_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .zero_o  (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        oh_d     = oh_q;
        dir_d    = dir_q;
        arrive_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    unique case (cmd_op)
                        OP_OPEN: begin
                            state_d  = S_OPEN;
                            tmr_load = 1'b1;
                            tmr_val  = DOOR_LD;
                        end
                        OP_UP: begin
                            if (floor_q != TOP_FLOOR) begin
                                state_d  = S_MOVE;
                                dir_d    = 1'b1;
                                tmr_load = 1'b1;
                                tmr_val  = TRAVEL_LD;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_DOWN: begin
                            if (floor_q != 3'd0) begin
                                state_d  = S_MOVE;
                                dir_d    = 1'b0;
                                tmr_load = 1'b1;
                                tmr_val  = TRAVEL_LD;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_RSVD: err_d = 1'b1;
                    endcase
                end
            end
            S_MOVE: begin
                if (tmr_zero) begin
                    state_d  = S_IDLE;
                    arrive_d = 1'b1;
                    if (dir_q) begin
                        floor_d = floor_q + 3'd1;
                        oh_d    = oh_q << 1;
                    end else begin
                        floor_d = floor_q - 3'd1;
                        oh_d    = oh_q >> 1;
                    end
                end
            end
            S_OPEN: begin
                if (tmr_zero) begin
                    state_d  = S_CLOSE;
                    tmr_load = 1'b1;
                    tmr_val  = CLOSE_LD;
                end
            end
            S_CLOSE: begin
`ifdef DOOR_REOPEN_EN
                // an obstruction wins even on the last close clock
                if (obstruct) begin
                    state_d  = S_OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LD;
                end else if (tmr_zero) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
`else
                if (tmr_zero) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            floor_q  <= 3'd0;
            oh_q     <= NUM_FLOORS'(1);
            dir_q    <= 1'b1;
            arrive_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            oh_q     <= oh_d;
            dir_q    <= dir_d;
            arrive_q <= arrive_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign moving    = (state_q == S_MOVE);
    assign door_open = (state_q == S_OPEN) || (state_q == S_CLOSE);
    assign floor_idx = floor_q;
    assign floor_oh  = oh_q;
    assign dir_up    = dir_q;
    assign arrive    = arrive_q;
    assign door_done = done_q;
    assign cmd_err   = err_q;

endmodule

// File: tb/tb_car_motion_responder.sv
// Bench for car_motion_responder: schedule-based reference model plus directed scenarios.
// Honours DOOR_REOPEN_EN when the design is built with it.
module tb_car_motion_responder;

    localparam int NF     = 8;
    localparam int TRAVEL = 16;
    localparam int DOOR   = 32;
    localparam int CLOSE  = 8;
`ifdef DOOR_REOPEN_EN
    localparam bit REOPEN = 1'b1;
`else
    localparam bit REOPEN = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic          cmd_ready;
    logic [NF-1:0] floor_oh;
    logic [2:0]    floor_idx;
    logic          moving;
    logic          dir_up;
    logic          door_open;
    logic          arrive;
    logic          door_done;
    logic          cmd_err;
    logic          obstruct;

    int checks = 0;
    int errors = 0;

    car_motion_responder #(
        .NUM_FLOORS    (NF),
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DOOR),
        .CLOSE_CYCLES  (CLOSE),
        .TIMER_W       (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .floor_oh  (floor_oh),
        .floor_idx (floor_idx),
        .moving    (moving),
        .dir_up    (dir_up),
        .door_open (door_open),
        .arrive    (arrive),
        .door_done (door_done),
        .cmd_err   (cmd_err),
        .obstruct  (obstruct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each operation is a scheduled completion edge, not a state machine.
    localparam int K_IDLE = 0;
    localparam int K_MOVE = 1;
    localparam int K_DOOR = 2;
    int m_cyc   = 0;
    int m_floor = 0;
    int m_end   = 0;
    int m_kind  = K_IDLE;
    bit m_dir   = 1'b1;
    bit m_arr   = 1'b0;
    bit m_done  = 1'b0;
    bit m_err   = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cyc = 0; m_floor = 0; m_end = 0; m_kind = K_IDLE;
            m_dir = 1'b1; m_arr = 1'b0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_cyc++;
            m_arr = 1'b0; m_done = 1'b0; m_err = 1'b0;
            if (REOPEN && m_kind == K_DOOR && obstruct === 1'b1
                && m_cyc > m_end - CLOSE) begin
                m_end = m_cyc + DOOR + CLOSE;
            end else if (m_kind != K_IDLE && m_cyc == m_end) begin
                if (m_kind == K_MOVE) begin
                    m_floor = m_dir ? m_floor + 1 : m_floor - 1;
                    m_arr = 1'b1;
                end else begin
                    m_done = 1'b1;
                end
                m_kind = K_IDLE;
            end else if (m_kind == K_IDLE && cmd_valid === 1'b1) begin
                if (cmd_op == 2'b00) begin
                    m_kind = K_DOOR; m_end = m_cyc + DOOR + CLOSE;
                end else if (cmd_op == 2'b01 && m_floor < NF - 1) begin
                    m_kind = K_MOVE; m_dir = 1'b1; m_end = m_cyc + TRAVEL;
                end else if (cmd_op == 2'b10 && m_floor > 0) begin
                    m_kind = K_MOVE; m_dir = 1'b0; m_end = m_cyc + TRAVEL;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset_n === 1'b1) begin
            chk("cmp_ready", cmd_ready, m_kind == K_IDLE);
            chk("cmp_moving", moving, m_kind == K_MOVE);
            chk("cmp_door_open", door_open, m_kind == K_DOOR);
            chk("cmp_floor_idx", floor_idx, m_floor);
            chk("cmp_floor_oh", floor_oh, 32'd1 << m_floor);
            chk("cmp_dir_up", dir_up, m_dir);
            chk("cmp_arrive", arrive, m_arr);
            chk("cmp_door_done", door_done, m_done);
            chk("cmp_cmd_err", cmd_err, m_err);
        end
    end

    task automatic issue(input logic [1:0] op);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_arrive(output int t, output int mcnt);
        t = 0;
        mcnt = 0;
        while (arrive !== 1'b1 && t < 100) begin
            if (moving === 1'b1) mcnt++;
            @(negedge clk);
            t++;
        end
    endtask

    task automatic door_cycle(input int obs_at, output int t, output int ocnt, output int rcnt);
        t = 0;
        ocnt = 0;
        rcnt = 0;
        while (door_done !== 1'b1 && t < 200) begin
            obstruct = (t == obs_at);
            if (door_open === 1'b1) ocnt++;
            if (cmd_ready === 1'b1) rcnt++;
            @(negedge clk);
            t++;
        end
        obstruct = 1'b0;
    endtask

    initial begin
        int t, c1, c2, arrivals, guard;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        obstruct  = 1'b0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_floor_idx", floor_idx, 3'd0);
        chk("rst_floor_oh", floor_oh, 8'h01);
        chk("rst_moving", moving, 1'b0);
        chk("rst_door_open", door_open, 1'b0);
        chk("rst_pulses", {arrive, door_done, cmd_err}, 3'b000);
        chk("rst_dir_up", dir_up, 1'b1);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1'b1);

        issue(2'b01);
        wait_arrive(t, c1);
        chk("up_latency", t, TRAVEL);
        chk("up_moving_clks", c1, 16);
        chk("up_floor_idx", floor_idx, 3'd1);
        chk("up_floor_oh", floor_oh, 8'h02);

        issue(2'b10);
        wait_arrive(t, c1);
        chk("down_latency", t, TRAVEL);
        chk("down_floor_oh", floor_oh, 8'h01);
        chk("down_dir_up", dir_up, 1'b0);

        issue(2'b10);
        chk("bottom_err", cmd_err, 1'b1);
        chk("bottom_ready", cmd_ready, 1'b1);
        chk("bottom_floor_oh", floor_oh, 8'h01);
        chk("bottom_moving", moving, 1'b0);
        @(negedge clk);
        chk("bottom_err_1clk", cmd_err, 1'b0);

        issue(2'b11);
        chk("rsvd_err", cmd_err, 1'b1);

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        arrivals  = 0;
        guard     = 0;
        while (arrivals < 7 && guard < 300) begin
            @(negedge clk);
            guard++;
            if (arrive === 1'b1) arrivals++;
        end
        chk("b2b_arrivals", arrivals, 7);
        chk("b2b_cycles", guard, 7 * (TRAVEL + 1));
        chk("b2b_floor_idx", floor_idx, 3'd7);
        chk("b2b_floor_oh", floor_oh, 8'h80);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("top_err", cmd_err, 1'b1);
        chk("top_floor_idx", floor_idx, 3'd7);

        issue(2'b00);
        door_cycle(-1, t, c1, c2);
        chk("door_latency", t, 40);
        chk("door_open_clks", c1, 40);
        chk("door_ready_clks", c2, 0);
        chk("door_closed", door_open, 1'b0);

        issue(2'b00);
        door_cycle(34, t, c1, c2);
        chk("obst_latency", t, REOPEN ? 75 : 40);
        chk("obst_open_clks", c1, REOPEN ? 75 : 40);
        chk("obst_ready_clks", c2, 0);

        repeat (3) begin
            issue(2'b10);
            wait_arrive(t, c1);
        end
        chk("pre_rst_floor", floor_idx, 3'd4);

        issue(2'b01);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("amid_moving", moving, 1'b0);
        chk("amid_floor_idx", floor_idx, 3'd0);
        chk("amid_floor_oh", floor_oh, 8'h01);
        chk("amid_arrive", arrive, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        c1 = 0;
        repeat (30) begin
            @(negedge clk);
            if (arrive === 1'b1) c1++;
        end
        chk("amid_no_arrive", c1, 0);
        chk("amid_final_floor", floor_idx, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
